// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and defaults for the bit-serial adder
package serial_adder_pkg;

  // FSM encoding; values are fixed so state can be observed and compared directly.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operand width used when the instantiating level does not override it.
  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - single-bit combinational full-adder cell
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and majority carry of the three input bits.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder_seq.sv
// rtl/serial_adder_seq.sv - bit-serial adder, one full-adder cell reused LSB first over WIDTH cycles
module serial_adder_seq
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf_out,
  output logic             done_valid,
  input  logic             done_ready
);

  localparam int CW = $clog2(WIDTH) + 1;
  // Counter value on the edge that adds the MSB, and the one just before it.
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PREV = CW'(WIDTH - 2);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_c_msb_in;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_cout_out;
  logic             r_ovf_out;
  logic             r_done_valid;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_sum_next;

  full_adder_bit u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  // Sum register after absorbing this cycle's bit at the top.
  assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};

  // Operands accepted only in IDLE, and never while reset is held.
  assign start_ready = rst_n && (r_state == ST_IDLE);

  assign sum_out    = r_sum_out;
  assign cout_out   = r_cout_out;
  assign ovf_out    = r_ovf_out;
  assign done_valid = r_done_valid;

  // Control FSM, bit counter, shift registers and registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_carry      <= 1'b0;
      r_c_msb_in   <= 1'b0;
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_sum_sh     <= '0;
      r_sum_out    <= '0;
      r_cout_out   <= 1'b0;
      r_ovf_out    <= 1'b0;
      r_done_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_valid) begin
            r_a_sh  <= a_in;
            r_b_sh  <= b_in;
            r_carry <= cin_in;
            r_cnt   <= '0;
            r_state <= ST_ADD;
          end
        end
        ST_ADD: begin
          r_sum_sh <= w_sum_next;
          r_carry  <= w_c;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_cnt    <= r_cnt + 1'b1;
          // Carry into the MSB is kept to derive signed overflow at the end.
          if (r_cnt == CNT_PREV) begin
            r_c_msb_in <= w_c;
          end
          if (r_cnt == CNT_LAST) begin
            r_sum_out    <= w_sum_next;
            r_cout_out   <= w_c;
            r_ovf_out    <= w_c ^ r_c_msb_in;
            r_done_valid <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (done_ready) begin
            r_done_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb/tb_serial_adder_seq.sv - directed self-checking bench for serial_adder_seq at WIDTH 4 and 8
module tb_serial_adder_seq;

  logic       clk;
  logic       rst_n;

  logic       sv4, sr4, cin4, co4, ov4, dv4, dr4;
  logic [3:0] a4, b4, s4;
  logic       sv8, sr8, cin8, co8, ov8, dv8, dr8;
  logic [7:0] a8, b8, s8;

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(sv4), .start_ready(sr4),
    .a_in(a4), .b_in(b4), .cin_in(cin4),
    .sum_out(s4), .cout_out(co4), .ovf_out(ov4),
    .done_valid(dv4), .done_ready(dr4)
  );

  serial_adder_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(sv8), .start_ready(sr8),
    .a_in(a8), .b_in(b8), .cin_in(cin8),
    .sum_out(s8), .cout_out(co8), .ovf_out(ov8),
    .done_valid(dv8), .done_ready(dr8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full WIDTH=4 operation with latency, result and return-to-IDLE checks.
  task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b, input logic cin,
                     input logic [3:0] es, input logic ec, input logic eo);
    a4 = a; b4 = b; cin4 = cin; sv4 = 1'b1; dr4 = 1'b0;
    check_eq({tag, " start_ready"}, 32'(sr4), 32'd1);
    tick();
    sv4 = 1'b0; a4 = ~a; b4 = ~b; cin4 = ~cin;
    check_eq({tag, " busy"}, 32'(sr4), 32'd0);
    repeat (3) tick();
    check_eq({tag, " dv early"}, 32'(dv4), 32'd0);
    tick();
    check_eq({tag, " dv latency"}, 32'(dv4), 32'd1);
    check_eq({tag, " sum"}, 32'(s4), 32'(es));
    check_eq({tag, " cout"}, 32'(co4), 32'(ec));
    check_eq({tag, " ovf"}, 32'(ov4), 32'(eo));
    dr4 = 1'b1;
    tick();
    dr4 = 1'b0;
    check_eq({tag, " dv clear"}, 32'(dv4), 32'd0);
    check_eq({tag, " idle"}, 32'(sr4), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    sv4 = 0; a4 = 0; b4 = 0; cin4 = 0; dr4 = 0;
    sv8 = 0; a8 = 0; b8 = 0; cin8 = 0; dr8 = 0;
    #1;
    check_eq("rst start_ready forced", 32'(sr4), 32'd0);
    repeat (2) tick();
    check_eq("rst sum", 32'(s4), 32'd0);
    check_eq("rst cout", 32'(co4), 32'd0);
    check_eq("rst ovf", 32'(ov4), 32'd0);
    check_eq("rst dv", 32'(dv4), 32'd0);
    check_eq("rst dv8", 32'(dv8), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("post rst idle", 32'(sr4), 32'd1);

    op4("7+9", 4'd7, 4'd9, 1'b0, 4'd0, 1'b1, 1'b0);
    op4("7+1", 4'd7, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1);
    op4("15+15+1", 4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0);

    // Back-pressure with start_valid held high throughout.
    a4 = 4'd3; b4 = 4'd5; cin4 = 1'b0; sv4 = 1'b1; dr4 = 1'b0;
    tick();
    a4 = 4'd2; b4 = 4'd2;
    repeat (4) tick();
    check_eq("bp dv", 32'(dv4), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("bp hold dv", 32'(dv4), 32'd1);
      check_eq("bp hold sum", 32'(s4), 32'd8);
      check_eq("bp hold ovf", 32'(ov4), 32'd1);
      check_eq("bp no accept", 32'(sr4), 32'd0);
    end
    dr4 = 1'b1;
    tick();
    dr4 = 1'b0;
    check_eq("bp back idle", 32'(sr4), 32'd1);
    check_eq("bp dv low", 32'(dv4), 32'd0);
    check_eq("bp keep sum", 32'(s4), 32'd8);
    tick();
    sv4 = 1'b0;
    check_eq("bp next accepted", 32'(sr4), 32'd0);
    repeat (3) tick();
    check_eq("bp2 dv early", 32'(dv4), 32'd0);
    tick();
    check_eq("bp2 dv", 32'(dv4), 32'd1);
    check_eq("bp2 sum", 32'(s4), 32'd4);
    dr4 = 1'b1;
    tick();
    dr4 = 1'b0;

    // Reset two bit edges into an addition aborts it and clears the result.
    a4 = 4'd9; b4 = 4'd9; cin4 = 1'b0; sv4 = 1'b1;
    tick();
    sv4 = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check_eq("mid rst ready low", 32'(sr4), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("mid rst idle", 32'(sr4), 32'd1);
    check_eq("mid rst sum", 32'(s4), 32'd0);
    check_eq("mid rst cout", 32'(co4), 32'd0);
    check_eq("mid rst ovf", 32'(ov4), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("mid rst no dv", 32'(dv4), 32'd0);
    end
    op4("3+4", 4'd3, 4'd4, 1'b0, 4'd7, 1'b0, 1'b0);

    // WIDTH=8 operation, 8-edge latency.
    a8 = 8'd200; b8 = 8'd100; cin8 = 1'b0; sv8 = 1'b1;
    check_eq("w8 ready", 32'(sr8), 32'd1);
    tick();
    sv8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    repeat (7) tick();
    check_eq("w8 dv early", 32'(dv8), 32'd0);
    tick();
    check_eq("w8 dv", 32'(dv8), 32'd1);
    check_eq("w8 sum", 32'(s8), 32'd44);
    check_eq("w8 cout", 32'(co8), 32'd1);
    check_eq("w8 ovf", 32'(ov8), 32'd0);
    dr8 = 1'b1;
    tick();
    dr8 = 1'b0;
    check_eq("w8 dv clear", 32'(dv8), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Bit-serial adder that feeds one full-adder cell and consumes its outputs; it adds two WIDTH-bit operands in WIDTH cycles, LSB first, with the carry kept in a register.
- Used in place of the 4-cell ripple chain where area matters more than latency.
- Operand intake and result return both use valid/ready handshakes.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 2..32.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start_valid  in  1  operands a_in, b_in and cin_in are valid.
- start_ready  out  1  block can accept operands (high in IDLE only).
- a_in  in  WIDTH  operand A; sampled on the accept edge only.
- b_in  in  WIDTH  operand B; sampled on the accept edge only.
- cin_in  in  1  initial carry-in; sampled on the accept edge only.
- sum_out  out  WIDTH  registered sum.
- cout_out  out  1  registered final carry-out.
- ovf_out  out  1  registered signed (two's-complement) overflow.
- done_valid  out  1  result outputs are valid.
- done_ready  in  1  consumer accepts the result.

Behaviour:
- FSM states: IDLE, ADD, DONE.
- Reset: an edge with rst_n=0 sets the state to IDLE, bit counter 0, carry 0, and clears the shift registers.
- Reset values: sum_out=0, cout_out=0, ovf_out=0, done_valid=0.
- start_ready is forced to 0 while rst_n=0.
- Reset mid-ADD or mid-DONE aborts the operation. No result is produced.
- IDLE:
  - start_ready = 1 and done_valid = 0.
  - Accept edge: start_valid & start_ready.
  - On the accept edge: a_sh <= a_in, b_sh <= b_in, carry <= cin_in, cnt <= 0, state -> ADD.
- ADD (one bit per edge):
  - The cell computes s and c from a_sh[0], b_sh[0] and carry.
  - Each edge: sum_sh <= {s, sum_sh[WIDTH-1:1]}, carry <= c, a_sh and b_sh shift right by 1, cnt <= cnt+1.
  - On the edge where cnt = WIDTH-2, save the current c as c_msb_in (carry into the MSB).
  - On the edge where cnt = WIDTH-1:
    - sum_out <= final sum_sh including this bit
    - cout_out <= c
    - ovf_out <= c XOR c_msb_in
    - done_valid <= 1
    - state -> DONE
- Latency: done_valid rises exactly WIDTH edges after the accept edge.
- DONE:
  - Outputs are held stable while done_ready = 0; unbounded back-pressure is allowed.
  - On an edge with done_ready = 1: done_valid <= 0, state -> IDLE.
  - start_valid is ignored and start_ready = 0.
- Throughput: one result per WIDTH+2 cycles at best (accept, WIDTH bit edges, one IDLE cycle).
- sum_out, cout_out and ovf_out keep the last result after returning to IDLE, until the next operation completes or reset.
- done_ready asserted outside DONE has no effect.
- a_in, b_in and cin_in may change at any time except on the accept edge.
- Width rules:
  - cnt is $clog2(WIDTH)+1 bits.
  - The sum wraps modulo 2^WIDTH, with the carry reported on cout_out.

Decomposition:
- Package serial_adder_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2
  - a default-width constant
- Sub-module full_adder_bit (a, b, cin -> s, cout), purely combinational, instantiated once.
- The FSM, counter and shift registers stay in serial_adder_seq.

Test Plan:
- WIDTH=4: a=7, b=9, cin=0.
  - Required: sum_out=0, cout_out=1, ovf_out=0.
  - done_valid rises 4 edges after accept.
- WIDTH=4: a=7, b=1, cin=0.
  - Required: sum_out=8, cout_out=0, ovf_out=1.
- WIDTH=4: a=15, b=15, cin=1.
  - Required: sum_out=15, cout_out=1, ovf_out=0.
- WIDTH=4 back-pressure: done_ready=0 for 3 cycles after done_valid, with start_valid held high throughout.
  - Required: outputs stable, start_ready=0, no second accept.
  - When done_ready=1, return to IDLE, then accept the next operand the following edge.
- Reset mid-ADD: assert rst_n=0 for 1 edge after 2 bit edges.
  - Required: state IDLE, all outputs 0, no done_valid.
  - A fresh operation 3+4 then yields sum_out=7.
- WIDTH=8: a=200, b=100, cin=0.
  - Required: sum_out=44, cout_out=1, ovf_out=0.
  - Latency is 8 edges.
